// File: rtl/hash_wb_pkg.sv
// Shared definitions for the Wishbone hash block controller:
// register word indices, CTRL/STATUS bit positions, FSM state enum.
package hash_wb_pkg;

  localparam int IDXW = 5;

  localparam logic [6:0] IDX_CTRL = 7'd0;
  localparam logic [6:0] IDX_STAT = 7'd1;
  localparam logic [6:0] IDX_CNT  = 7'd2;

  localparam int C_START = 0;
  localparam int C_SOFT  = 1;
  localparam int C_IRQEN = 2;
  localparam int C_LAST  = 3;

  localparam int S_RDY  = 0;
  localparam int S_DV   = 1;
  localparam int S_Q    = 2;
  localparam int S_BUSY = 3;
  localparam int S_IRQ  = 4;
  localparam int S_OVR  = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_BUSY
  } state_e;

endpackage

// File: rtl/hash_blk_pingpong.sv
// Ping-pong block store: software-facing write buffer + LAST flag,
// core-facing issue buffer, and the queued flag that freezes the write side.
//  i_wr_*   word write into write buffer
//  i_last_* LAST flag write
//  i_copy   write side -> issue side
//  i_q_set/i_q_clr/i_soft  queued flag control
//  o_wbuf/o_ibuf/o_ilast/o_queued  buffer state
module hash_blk_pingpong
  import hash_wb_pkg::*;
#(
  parameter int DW    = 32,
  parameter int WORDS = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_soft,
  input  logic              i_wr_en,
  input  logic [IDXW-1:0]   i_wr_idx,
  input  logic [DW-1:0]     i_wr_data,
  input  logic              i_last_we,
  input  logic              i_last_d,
  input  logic              i_copy,
  input  logic              i_q_set,
  input  logic              i_q_clr,
  output logic [DW*WORDS-1:0] o_wbuf,
  output logic [DW*WORDS-1:0] o_ibuf,
  output logic              o_ilast,
  output logic              o_queued
);

  logic [DW*WORDS-1:0] r_wbuf;
  logic [DW*WORDS-1:0] r_ibuf;
  logic                r_wlast;
  logic                r_ilast;
  logic                r_queued;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wbuf   <= '0;
      r_ibuf   <= '0;
      r_wlast  <= 1'b0;
      r_ilast  <= 1'b0;
      r_queued <= 1'b0;
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (i_wr_en && i_wr_idx == IDXW'(i))
          r_wbuf[i*DW +: DW] <= i_wr_data;
      end
      if (i_last_we)
        r_wlast <= i_last_d;
      if (i_copy) begin
        r_ibuf  <= r_wbuf;
        r_ilast <= r_wlast;
      end
      if (i_soft || i_q_clr)
        r_queued <= 1'b0;
      else if (i_q_set)
        r_queued <= 1'b1;
    end
  end

  assign o_wbuf   = r_wbuf;
  assign o_ibuf   = r_ibuf;
  assign o_ilast  = r_ilast;
  assign o_queued = r_queued;

endmodule

// File: rtl/wb_hash_blk_ctrl.sv
// Wishbone slave feeding an external block hash core from a ping-pong buffer.
// Ports: wb_* bus slave, int_o irq, core_* hash core handshake/data.
module wb_hash_blk_ctrl
  import hash_wb_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int BLK_W = 512,
  parameter int DIG_W = 128
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [AW-1:0]    wb_adr_i,
  input  logic [DW-1:0]    wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  output logic [DW-1:0]    wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             int_o,
  output logic             core_rst,
  output logic             core_msg_valid,
  output logic [BLK_W-1:0] core_msg,
  input  logic             core_ready,
  input  logic             core_out_valid,
  input  logic [DIG_W-1:0] core_digest
);

  localparam int BW = BLK_W / DW;
  localparam int GW = DIG_W / DW;

  state_e           r_state, w_nstate;
  logic             r_ack, r_err, r_irq_en, r_start, r_soft, r_mv;
  logic             r_dv, r_irq, r_ovr;
  logic [DW-1:0]    r_dat, r_cnt;
  logic [DIG_W-1:0] r_dig;

  logic [6:0]       w_idx;
  logic             w_req, w_ok, w_is_buf, w_is_dig;
  logic             w_wr, w_ctrl_wr, w_stat_wr, w_buf_wr, w_soft;
  logic [DW-1:0]    w_rdata;
  logic [BLK_W-1:0] w_wbuf, w_ibuf;
  logic             w_ilast, w_queued;
  logic             w_copy, w_qset, w_qclr, w_mv, w_done;
  logic             w_dv_clr, w_ovr_set;
  logic             w_unused;

  assign w_unused = ^{wb_sel_i, wb_adr_i[AW-1:9], wb_adr_i[1:0]};

  assign w_idx    = wb_adr_i[8:2];
  assign w_req    = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
  assign w_is_buf = (w_idx[6:5] == 2'b01) && (int'(w_idx[4:0]) < BW);
  assign w_is_dig = (w_idx[6:5] == 2'b10) && (int'(w_idx[4:0]) < GW);

  always_comb begin
    w_ok = 1'b0;
    if (w_idx == IDX_CTRL || w_idx == IDX_STAT) w_ok = 1'b1;
    else if (w_idx == IDX_CNT) w_ok = ~wb_we_i;
    else if (w_is_buf) w_ok = ~wb_we_i | ~w_queued;
    else if (w_is_dig) w_ok = ~wb_we_i;
  end

  assign w_wr      = w_req & w_ok & wb_we_i;
  assign w_ctrl_wr = w_wr & (w_idx == IDX_CTRL);
  assign w_stat_wr = w_wr & (w_idx == IDX_STAT);
  assign w_buf_wr  = w_wr & w_is_buf;
  assign w_soft    = w_ctrl_wr & wb_dat_i[C_SOFT];

  always_comb begin
    w_rdata = '0;
    if (w_idx == IDX_CTRL) begin
      w_rdata[C_IRQEN] = r_irq_en;
    end else if (w_idx == IDX_STAT) begin
      w_rdata[S_RDY]  = core_ready;
      w_rdata[S_DV]   = r_dv;
      w_rdata[S_Q]    = w_queued;
      w_rdata[S_BUSY] = (r_state != ST_IDLE);
      w_rdata[S_IRQ]  = r_irq;
      w_rdata[S_OVR]  = r_ovr;
    end else if (w_idx == IDX_CNT) begin
      w_rdata = r_cnt;
    end else if (w_is_buf) begin
      for (int i = 0; i < BW; i++)
        if (w_idx[4:0] == 5'(i)) w_rdata = w_wbuf[i*DW +: DW];
    end else if (w_is_dig) begin
      for (int i = 0; i < GW; i++)
        if (w_idx[4:0] == 5'(i)) w_rdata = r_dig[i*DW +: DW];
    end
  end

  // Completion is handled before a coincident START: a queued block
  // wins, otherwise the fresh START is copied directly.
  always_comb begin
    w_nstate  = r_state;
    w_copy    = 1'b0;
    w_qset    = 1'b0;
    w_qclr    = 1'b0;
    w_mv      = 1'b0;
    w_done    = 1'b0;
    w_dv_clr  = 1'b0;
    w_ovr_set = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_start) begin
          w_copy   = 1'b1;
          w_dv_clr = 1'b1;
          w_nstate = ST_PEND;
        end
      end
      ST_PEND: begin
        if (core_ready) begin
          w_mv     = 1'b1;
          w_nstate = ST_BUSY;
        end
        if (r_start) begin
          w_ovr_set = w_queued;
          w_qset    = ~w_queued;
        end
      end
      ST_BUSY: begin
        if (core_out_valid) begin
          w_done = 1'b1;
          if (w_queued) begin
            w_copy    = 1'b1;
            w_qclr    = 1'b1;
            w_ovr_set = r_start;
            w_nstate  = ST_PEND;
          end else if (r_start) begin
            w_copy   = 1'b1;
            w_dv_clr = 1'b1;
            w_nstate = ST_PEND;
          end else begin
            w_nstate = ST_IDLE;
          end
        end else if (r_start) begin
          w_ovr_set = w_queued;
          w_qset    = ~w_queued;
        end
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= ST_IDLE;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_dat    <= '0;
      r_irq_en <= 1'b0;
      r_start  <= 1'b0;
      r_soft   <= 1'b0;
      r_mv     <= 1'b0;
      r_dv     <= 1'b0;
      r_irq    <= 1'b0;
      r_ovr    <= 1'b0;
      r_cnt    <= '0;
      r_dig    <= '0;
    end else begin
      r_ack  <= w_req & w_ok;
      r_err  <= w_req & ~w_ok;
      r_dat  <= (w_req & w_ok & ~wb_we_i) ? w_rdata : '0;
      r_soft <= w_soft;
      if (w_ctrl_wr) r_irq_en <= wb_dat_i[C_IRQEN];
      if (w_soft) begin
        r_state <= ST_IDLE;
        r_start <= 1'b0;
        r_mv    <= 1'b0;
        r_dv    <= 1'b0;
        r_irq   <= 1'b0;
        r_ovr   <= 1'b0;
      end else begin
        r_state <= w_nstate;
        r_start <= w_ctrl_wr & wb_dat_i[C_START];
        r_mv    <= w_mv;
        if (w_done) begin
          r_cnt <= r_cnt + 1'b1;
          r_dig <= core_digest;
        end
        if (w_dv_clr) r_dv <= 1'b0;
        else if (w_done & w_ilast) r_dv <= 1'b1;
        if (w_done & w_ilast) r_irq <= 1'b1;
        else if (w_stat_wr & wb_dat_i[S_IRQ]) r_irq <= 1'b0;
        if (w_ovr_set) r_ovr <= 1'b1;
        else if (w_stat_wr & wb_dat_i[S_OVR]) r_ovr <= 1'b0;
      end
    end
  end

  hash_blk_pingpong #(.DW(DW), .WORDS(BW)) u_pp (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_soft    (w_soft),
    .i_wr_en   (w_buf_wr),
    .i_wr_idx  (w_idx[4:0]),
    .i_wr_data (wb_dat_i),
    .i_last_we (w_ctrl_wr & ~w_queued),
    .i_last_d  (wb_dat_i[C_LAST]),
    .i_copy    (w_copy & ~w_soft),
    .i_q_set   (w_qset & ~w_soft),
    .i_q_clr   (w_qclr),
    .o_wbuf    (w_wbuf),
    .o_ibuf    (w_ibuf),
    .o_ilast   (w_ilast),
    .o_queued  (w_queued)
  );

  assign wb_dat_o       = r_dat;
  assign wb_ack_o       = r_ack;
  assign wb_err_o       = r_err;
  assign int_o          = r_irq & r_irq_en;
  assign core_rst       = wb_rst_i | r_soft;
  assign core_msg_valid = r_mv;
  assign core_msg       = w_ibuf;

endmodule

// File: tb/tb_wb_hash_blk_ctrl.sv
// Self-checking bench for wb_hash_blk_ctrl: register table vectors,
// hand sequences for queueing/soft reset, randomized blocks vs a model.
module tb_wb_hash_blk_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  adr, wdat, rdat;
  logic [3:0]   sel;
  logic         cyc, stb, we;
  logic         ack, err, irq, crst, mv;
  logic [511:0] msg;
  logic         rdy, ov;
  logic [127:0] dig;

  always #5 clk = ~clk;

  wb_hash_blk_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_sel_i(sel), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_dat_o(rdat), .wb_ack_o(ack), .wb_err_o(err), .int_o(irq),
    .core_rst(crst), .core_msg_valid(mv), .core_msg(msg),
    .core_ready(rdy), .core_out_valid(ov), .core_digest(dig)
  );

  int n_vec = 0;
  int n_bad = 0;
  int mv_cnt = 0;
  int crst_cnt = 0;
  logic [511:0] last_msg = '0;

  always @(posedge clk) begin
    if (mv) begin
      mv_cnt++;
      last_msg = msg;
    end
    if (crst && !rst) crst_cnt++;
  end

  function automatic void chk(input string nm,
                              input logic [511:0] got,
                              input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endfunction

  task automatic bus(input bit w, input int idx, input logic [31:0] d,
                     output logic [31:0] q, output bit a, output bit e);
    bit got;
    got = 0; q = '0; a = 0; e = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = 32'(idx) << 2; wdat = d;
    for (int n = 0; n < 8 && !got; n++) begin
      @(posedge clk); #1;
      if (ack || err) begin
        got = 1; a = ack; e = err; q = rdat;
      end
    end
    cyc = 0; stb = 0; we = 0;
    if (!got) begin
      n_vec++; n_bad++;
      $display("FAIL bus_timeout idx=%0d", idx);
    end
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    logic [31:0] q; bit a, e;
    bus(1, idx, d, q, a, e);
    chk($sformatf("wr_ack_%0d", idx), {511'b0, a}, 512'd1);
  endtask

  task automatic rd_chk(input string nm, input int idx,
                        input logic [31:0] exp);
    logic [31:0] q; bit a, e;
    bus(0, idx, 32'h0, q, a, e);
    chk(nm, {480'b0, q}, {480'b0, exp});
  endtask

  task automatic load(input logic [511:0] b);
    for (int i = 0; i < 16; i++) wr(32 + i, b[i*32 +: 32]);
  endtask

  task automatic wait_mv(input int prev, input string nm);
    for (int n = 0; n < 30 && mv_cnt == prev; n++) @(negedge clk);
    chk(nm, 512'(mv_cnt), 512'(prev + 1));
  endtask

  task automatic pulse_ov(input logic [127:0] d);
    @(negedge clk); ov = 1; dig = d;
    @(negedge clk); ov = 0;
  endtask

  typedef struct {
    bit          w;
    int          idx;
    logic [31:0] wd;
    bit          eerr;
    bit          chkd;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [511:0] blk, blk_b;
    logic [127:0] d, d_b;
    logic [31:0]  q;
    bit a, e, last;
    int p, p0, c, m_cnt, k;

    tbl[0]  = '{0, 1,  32'h0,    0, 1, 32'h0};
    tbl[1]  = '{0, 5,  32'h0,    1, 0, 32'h0};
    tbl[2]  = '{0, 2,  32'h0,    0, 1, 32'h0};
    tbl[3]  = '{1, 2,  32'h1,    1, 0, 32'h0};
    tbl[4]  = '{1, 64, 32'h1,    1, 0, 32'h0};
    tbl[5]  = '{0, 64, 32'h0,    0, 1, 32'h0};
    tbl[6]  = '{1, 0,  32'h4,    0, 0, 32'h0};
    tbl[7]  = '{0, 0,  32'h0,    0, 1, 32'h4};
    tbl[8]  = '{1, 0,  32'h0,    0, 0, 32'h0};
    tbl[9]  = '{0, 0,  32'h0,    0, 1, 32'h0};
    tbl[10] = '{1, 32, 32'hA5A5, 0, 0, 32'h0};
    tbl[11] = '{0, 32, 32'h0,    0, 1, 32'hA5A5};
    tbl[12] = '{0, 48, 32'h0,    1, 0, 32'h0};
    tbl[13] = '{0, 68, 32'h0,    1, 0, 32'h0};
    tbl[14] = '{1, 3,  32'h7,    1, 0, 32'h0};
    tbl[15] = '{0, 47, 32'h0,    0, 1, 32'h0};

    rst = 1; adr = 0; wdat = 0; sel = 4'hF; cyc = 0; stb = 0; we = 0;
    rdy = 0; ov = 0; dig = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {475'b0, ack, err, irq, mv, rdat},
        512'b0);
    chk("reset_msg", msg, 512'b0);
    rst = 0;
    @(negedge clk);
    chk("core_rst_idle", {511'b0, crst}, 512'b0);

    for (int i = 0; i < 16; i++) begin
      bus(tbl[i].w, tbl[i].idx, tbl[i].wd, q, a, e);
      chk($sformatf("tbl%0d_err", i), {510'b0, a, e},
          {510'b0, !tbl[i].eerr, tbl[i].eerr});
      if (tbl[i].chkd)
        chk($sformatf("tbl%0d_dat", i), {480'b0, q},
            {480'b0, tbl[i].erd});
    end

    rdy = 1;
    for (int i = 0; i < 16; i++) blk[i*32 +: 32] = 32'(i);
    load(blk);
    p0 = mv_cnt;
    wr(0, 32'h9);
    wait_mv(p0, "mv_first");
    chk("msg_lo", {480'b0, last_msg[31:0]}, 512'h0);
    chk("msg_hi", {480'b0, last_msg[511:480]}, 512'hF);
    d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    pulse_ov(d);
    for (int i = 0; i < 4; i++)
      rd_chk($sformatf("dig%0d", i), 64 + i, d[i*32 +: 32]);
    rd_chk("cnt1", 2, 32'd1);
    rd_chk("stat1", 1, 32'h13);
    chk("int_masked", {511'b0, irq}, 512'b0);
    chk("single_mv", 512'(mv_cnt - p0), 512'd1);

    wr(0, 32'h4);
    chk("int_on", {511'b0, irq}, 512'd1);
    wr(1, 32'h10);
    chk("int_w1c", {511'b0, irq}, 512'b0);

    for (int i = 0; i < 16; i++) blk[i*32 +: 32] = 32'hA000_0000 + i;
    for (int i = 0; i < 16; i++) blk_b[i*32 +: 32] = 32'hB000_0000 + i;
    load(blk);
    p0 = mv_cnt;
    wr(0, 32'h5);
    wait_mv(p0, "mv_a");
    chk("msg_a", last_msg, blk);
    load(blk_b);
    wr(0, 32'hD);
    bus(1, 32, 32'hDEAD, q, a, e);
    chk("wbuf_locked_err", {510'b0, a, e}, 512'd1);
    wr(0, 32'hD);
    rd_chk("stat_q_ovr", 1, 32'h2D);
    p = mv_cnt;
    d = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    pulse_ov(d);
    wait_mv(p, "mv_b");
    chk("msg_b", last_msg, blk_b);
    d_b = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
    pulse_ov(d_b);
    repeat (5) @(negedge clk);
    chk("two_mv", 512'(mv_cnt - p0), 512'd2);
    rd_chk("cnt3", 2, 32'd3);
    rd_chk("stat_b", 1, 32'h33);
    chk("int_b", {511'b0, irq}, 512'd1);
    rd_chk("dig_b", 64, d_b[31:0]);
    wr(1, 32'h30);
    rd_chk("stat_clr", 1, 32'h03);

    p = mv_cnt;
    wr(0, 32'h1);
    wait_mv(p, "mv_soft");
    c = crst_cnt;
    wr(0, 32'h2);
    repeat (4) @(negedge clk);
    chk("crst_pulse", 512'(crst_cnt - c), 512'd1);
    rd_chk("stat_soft", 1, 32'h01);
    rd_chk("cnt_soft", 2, 32'd3);
    pulse_ov(128'hFFFF);
    rd_chk("cnt_stray", 2, 32'd3);
    rd_chk("dig_stray", 64, d_b[31:0]);
    rd_chk("stat_stray", 1, 32'h01);

    m_cnt = 3;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 16; i++) blk[i*32 +: 32] = $urandom;
      last = 1'($urandom % 2);
      d = {$urandom, $urandom, $urandom, $urandom};
      load(blk);
      rdy = 0;
      p = mv_cnt;
      wr(0, 32'h5 | (32'(last) << 3));
      repeat ($urandom_range(1, 4)) @(negedge clk);
      chk($sformatf("r%0d_hold", it), 512'(mv_cnt), 512'(p));
      rdy = 1;
      wait_mv(p, $sformatf("r%0d_mv", it));
      chk($sformatf("r%0d_msg", it), last_msg, blk);
      pulse_ov(d);
      m_cnt++;
      rd_chk($sformatf("r%0d_cnt", it), 2, 32'(m_cnt));
      k = $urandom % 4;
      rd_chk($sformatf("r%0d_dig", it), 64 + k, d[k*32 +: 32]);
      rd_chk($sformatf("r%0d_stat", it), 1, last ? 32'h13 : 32'h01);
      chk($sformatf("r%0d_int", it), {511'b0, irq}, {511'b0, last});
      wr(1, 32'h30);
    end

    p = mv_cnt;
    wr(0, 32'h1);
    wait_mv(p, "mv_rst");
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h4; rst = 1;
    @(posedge clk); #1;
    chk("rst_no_ack", {510'b0, ack, err}, 512'b0);
    @(negedge clk);
    cyc = 0; stb = 0; rst = 0;
    rd_chk("rst_cnt", 2, 32'd0);
    rd_chk("rst_stat", 1, 32'h01);
    rd_chk("rst_buf", 32, 32'h0);
    chk("rst_msg", msg, 512'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
